rrarb_wrr_nto1: RTL

Parametrised weighted round-robin arbiter for N requestors, the successor to the single-grant rotating arbiter in `spcom/rrarb`. It holds a registered one-hot grant for up to `weight[i]` acknowledged transfers per tenure. It supports a `lock` input for atomic bursts and re-arbitrates with zero bubble cycles. It sits in front of shared buses and memory ports where requestors need proportional bandwidth rather than equal single-beat turns.

---
 rtl/rrarb_pkg.sv | 18 +
 rtl/rrarb_rr_pick.sv | 41 ++++
 rtl/rrarb_wrr_nto1.sv | 95 +++++++++
 3 files changed

// File: rtl/rrarb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package rrarb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } rrarb_state_e;

  function automatic int unsigned rrarb_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rrarb_rr_pick.sv
// Combinational rotating-priority picker: lowest requestor above ptr wins, else wraps to lowest.
module rrarb_rr_pick #(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [REQ_CNT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [REQ_CNT-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [REQ_CNT-1:0] One = REQ_CNT'(1);

  logic [REQ_CNT-1:0] mask_hi;
  logic [REQ_CNT-1:0] hi;
  logic [REQ_CNT-1:0] hi_oh;
  logic [REQ_CNT-1:0] lo_oh;

  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < int'(REQ_CNT); i++) begin
      mask_hi[i] = (i > int'(ptr));
    end
  end

  assign hi    = req & mask_hi;
  assign hi_oh = hi & ~(hi - One);
  assign lo_oh = req & ~(req - One);

  assign any    = |req;
  assign onehot = (|hi) ? hi_oh : lo_oh;

  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(REQ_CNT); i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rrarb_wrr_nto1.sv
// Weighted round-robin N:1 arbiter: registered one-hot grant held for up to weight[i] acks,
// with lock for atomic bursts and zero-bubble handover.
module rrarb_wrr_nto1
  import rrarb_pkg::*;
#(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned WGT_W   = 4,
  parameter int unsigned IDX_W   = rrarb_clog2(REQ_CNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_CNT-1:0]       req,
  input  logic [REQ_CNT*WGT_W-1:0] weight,
  input  logic                     ack,
  input  logic                     lock,
  output logic [REQ_CNT-1:0]       grant,
  output logic                     grant_vld,
  output logic [IDX_W-1:0]         grant_idx
);

  localparam logic [WGT_W-1:0] CntOne = WGT_W'(1);

  rrarb_state_e       state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [WGT_W-1:0]   cnt_q;

  logic [REQ_CNT-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [WGT_W-1:0]   wsel;
  logic [WGT_W-1:0]   fresh_cnt;
  logic               rel;

  // ptr_q always holds the current owner, so one picker serves both IDLE and release.
  rrarb_rr_pick #(
    .REQ_CNT (REQ_CNT),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign wsel      = weight[int'(pick_idx)*int'(WGT_W) +: WGT_W];
  assign fresh_cnt = (wsel == '0) ? CntOne : wsel;

  assign rel = !lock && ((ack && (cnt_q == CntOne)) || (cnt_q == '0) || !req[grant_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(REQ_CNT - 1);
      cnt_q     <= '0;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q   <= GRANT;
            ptr_q     <= pick_idx;
            cnt_q     <= fresh_cnt;
            grant     <= pick_oh;
            grant_vld <= 1'b1;
            grant_idx <= pick_idx;
          end
        end
        GRANT: begin
          if (rel) begin
            if (pick_any) begin
              ptr_q     <= pick_idx;
              cnt_q     <= fresh_cnt;
              grant     <= pick_oh;
              grant_vld <= 1'b1;
              grant_idx <= pick_idx;
            end else begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              grant     <= '0;
              grant_vld <= 1'b0;
              grant_idx <= '0;
            end
          end else if (ack && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
